// File: rtl/demux1_64_frame_if.sv
`default_nettype none
// ============================================================================
// Module   : demux1_64_frame_if
// Brief    : Beat input, frame output and control bundle for demux1_64_frame.
// Revision : 1.0  initial release
// ============================================================================
interface demux1_64_frame_if #(
  parameter int WIDTH = 64,
  parameter int SEL_W = 6
);
  logic             clear;
  logic             in_valid;
  logic             in_ready;
  logic             in_bit;
  logic [SEL_W-1:0] select;
  logic             auto_mode;
  logic [WIDTH-1:0] written;
  logic [SEL_W-1:0] ptr;
  logic [WIDTH-1:0] frame_data;
  logic             out_valid;
  logic             out_ready;

  modport master (
    output clear, in_valid, in_bit, select, auto_mode, out_ready,
    input  in_ready, written, ptr, frame_data, out_valid
  );

  modport slave (
    input  clear, in_valid, in_bit, select, auto_mode, out_ready,
    output in_ready, written, ptr, frame_data, out_valid
  );
endinterface
`default_nettype wire

// File: rtl/demux1_64_frame.sv
`default_nettype none
// ============================================================================
// Module   : demux1_64_frame
// Brief    : Registered 1:64 bit demux that assembles a frame and hands it
//            off over a valid/ready handshake.
// Revision : 1.0  initial release
// ============================================================================
module demux1_64_frame #(
  parameter int WIDTH = 64,
  parameter int SEL_W = 6
) (
  input wire logic          clk,
  input wire logic          rst,
  demux1_64_frame_if.slave  bus
);

  typedef enum logic [0:0] {
    ST_FILL = 1'b0,
    ST_HOLD = 1'b1
  } state_t;

  localparam logic [WIDTH-1:0] c_one = {{(WIDTH-1){1'b0}}, 1'b1};

  state_t             r_state;
  state_t             w_state_next;
  logic [WIDTH-1:0]   r_frame;
  logic [WIDTH-1:0]   r_written;
  logic [SEL_W-1:0]   r_ptr;
  logic [SEL_W-1:0]   w_idx;
  logic [WIDTH-1:0]   w_mask_next;
  logic               w_accept;
  logic               w_complete;
  logic               w_handoff;

  // A beat arriving alongside clear is dropped, so clear gates acceptance.
  assign w_accept    = bus.in_valid && (r_state == ST_FILL) && !bus.clear;
  assign w_idx       = bus.auto_mode ? r_ptr : bus.select;
  assign w_mask_next = r_written | (c_one << w_idx);
  assign w_complete  = w_accept && (&w_mask_next);
  assign w_handoff   = (r_state == ST_HOLD) && bus.out_ready;

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      ST_FILL: if (w_complete) w_state_next = ST_HOLD;
      ST_HOLD: if (bus.out_ready) w_state_next = ST_FILL;
      default: w_state_next = ST_FILL;
    endcase
    if (bus.clear) w_state_next = ST_FILL;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state   <= ST_FILL;
      r_frame   <= '0;
      r_written <= '0;
      r_ptr     <= '0;
    end else begin
      r_state <= w_state_next;
      if (bus.clear || w_handoff) begin
        // frame_data deliberately survives flush and handoff
        r_written <= '0;
        r_ptr     <= '0;
      end else if (w_accept) begin
        r_frame[w_idx] <= bus.in_bit;
        r_written      <= w_mask_next;
        if (bus.auto_mode) r_ptr <= r_ptr + SEL_W'(1);
      end
    end
  end

  assign bus.in_ready   = (r_state == ST_FILL);
  assign bus.out_valid  = (r_state == ST_HOLD);
  assign bus.written    = r_written;
  assign bus.ptr        = r_ptr;
  assign bus.frame_data = r_frame;

endmodule
`default_nettype wire

// File: tb/tb_demux1_64_frame.sv
`default_nettype none
// ============================================================================
// Module   : tb_demux1_64_frame
// Brief    : Directed self-checking bench for demux1_64_frame.
// Revision : 1.0  initial release
// ============================================================================
module tb_demux1_64_frame;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_tests = 0;
  int   n_fail  = 0;

  always #5 clk = ~clk;

  demux1_64_frame_if #(.WIDTH(64), .SEL_W(6)) bus ();

  demux1_64_frame #(.WIDTH(64), .SEL_W(6)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Presents one cycle of inputs, then samples 1 time unit after the edge.
  task automatic step(input logic v, input logic am, input logic [5:0] sel, input logic b);
    bus.in_valid  = v;
    bus.auto_mode = am;
    bus.select    = sel;
    bus.in_bit    = b;
    @(posedge clk);
    #1;
    bus.in_valid  = 1'b0;
    bus.clear     = 1'b0;
    bus.out_ready = 1'b0;
  endtask

  task automatic handoff();
    bus.out_ready = 1'b1;
    step(1'b0, 1'b0, 6'd0, 1'b0);
  endtask

  initial begin
    bus.clear = 1'b0; bus.in_valid = 1'b0; bus.in_bit = 1'b0;
    bus.select = '0; bus.auto_mode = 1'b0; bus.out_ready = 1'b0;
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    check("rst_out_valid", {63'd0, bus.out_valid}, 64'd0);
    check("rst_in_ready",  {63'd0, bus.in_ready},  64'd1);
    check("rst_written",   bus.written, 64'd0);
    check("rst_ptr",       {58'd0, bus.ptr}, 64'd0);
    check("rst_frame",     bus.frame_data, 64'd0);

    // Auto sweep, in_bit = idx[0]
    for (int i = 0; i < 64; i++) begin
      if (i == 63) check("t1_no_early_valid", {63'd0, bus.out_valid}, 64'd0);
      step(1'b1, 1'b1, 6'd0, i[0]);
    end
    check("t1_out_valid", {63'd0, bus.out_valid}, 64'd1);
    check("t1_frame",     bus.frame_data, 64'hAAAA_AAAA_AAAA_AAAA);
    check("t1_ptr",       {58'd0, bus.ptr}, 64'd0);
    check("t1_written",   bus.written, {64{1'b1}});

    // Backpressure in HOLD
    for (int i = 0; i < 5; i++) begin
      step(1'b1, 1'b1, 6'd0, 1'b0);
      check("t2_in_ready", {63'd0, bus.in_ready}, 64'd0);
      check("t2_frame",    bus.frame_data, 64'hAAAA_AAAA_AAAA_AAAA);
    end
    handoff();
    check("t2_out_valid", {63'd0, bus.out_valid}, 64'd0);
    check("t2_in_ready",  {63'd0, bus.in_ready},  64'd1);
    check("t2_written",   bus.written, 64'd0);
    check("t2_frame_kept", bus.frame_data, 64'hAAAA_AAAA_AAAA_AAAA);

    // Duplicate index, then addressed reverse sweep
    step(1'b1, 1'b0, 6'd5, 1'b1);
    step(1'b1, 1'b0, 6'd5, 1'b0);
    check("t3_dup_bit5",    {63'd0, bus.frame_data[5]}, 64'd0);
    check("t3_dup_written", bus.written, 64'h0000_0000_0000_0020);
    check("t3_dup_nvalid",  {63'd0, bus.out_valid}, 64'd0);
    for (int i = 63; i >= 0; i--) begin
      if (i == 0) check("t3_no_early_valid", {63'd0, bus.out_valid}, 64'd0);
      step(1'b1, 1'b0, 6'(i), 1'b1);
    end
    check("t3_out_valid", {63'd0, bus.out_valid}, 64'd1);
    check("t3_frame",     bus.frame_data, {64{1'b1}});
    handoff();

    // Mixed modes
    for (int i = 0; i < 10; i++) step(1'b1, 1'b1, 6'd0, 1'b1);
    check("t4_ptr10", {58'd0, bus.ptr}, 64'd10);
    step(1'b1, 1'b0, 6'd40, 1'b0);
    check("t4_ptr_kept", {58'd0, bus.ptr}, 64'd10);
    check("t4_written",  bus.written, 64'h0000_0100_0000_03FF);
    for (int i = 10; i < 64; i++) step(1'b1, 1'b0, 6'(i), 1'b0);
    check("t4_out_valid", {63'd0, bus.out_valid}, 64'd1);
    check("t4_ptr_hold",  {58'd0, bus.ptr}, 64'd10);
    check("t4_frame",     bus.frame_data, 64'h0000_0000_0000_03FF);
    handoff();
    check("t4_ptr_after", {58'd0, bus.ptr}, 64'd0);

    // Clear mid-frame with a simultaneous beat
    for (int i = 0; i < 30; i++) step(1'b1, 1'b1, 6'd0, 1'b1);
    check("t5_ptr30",    {58'd0, bus.ptr}, 64'd30);
    check("t5_written",  bus.written, 64'h0000_0000_3FFF_FFFF);
    bus.clear = 1'b1;
    step(1'b1, 1'b1, 6'd0, 1'b1);
    check("t5_clr_written", bus.written, 64'd0);
    check("t5_clr_ptr",     {58'd0, bus.ptr}, 64'd0);
    check("t5_clr_frame",   bus.frame_data, 64'h0000_0000_3FFF_FFFF);
    check("t5_clr_nvalid",  {63'd0, bus.out_valid}, 64'd0);

    // Reset while holding a frame with out_ready high
    for (int i = 0; i < 64; i++) step(1'b1, 1'b1, 6'd0, 1'b1);
    check("t6_hold", {63'd0, bus.out_valid}, 64'd1);
    rst = 1'b1;
    bus.out_ready = 1'b1;
    step(1'b1, 1'b1, 6'd0, 1'b1);
    rst = 1'b0;
    check("t6_out_valid", {63'd0, bus.out_valid}, 64'd0);
    check("t6_in_ready",  {63'd0, bus.in_ready},  64'd1);
    check("t6_frame",     bus.frame_data, 64'd0);
    check("t6_written",   bus.written, 64'd0);
    check("t6_ptr",       {58'd0, bus.ptr}, 64'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
